// File: rtl/hci_core_arbiter_tracked_pkg.sv
// Shared types and defaults for the tracked 2-to-1 HCI core arbiter.
package hci_core_arbiter_tracked_pkg;

  localparam int unsigned DEFAULT_AW    = 32;
  localparam int unsigned DEFAULT_DW    = 32;
  localparam int unsigned HCI_BOFFS_W   = 16;
  localparam int unsigned HCI_ARB_SRC_W = 1;

  typedef logic [HCI_ARB_SRC_W-1:0] hci_arb_src_t;

  localparam hci_arb_src_t SRC_IN0 = 1'b0;
  localparam hci_arb_src_t SRC_IN1 = 1'b1;

endpackage

// File: rtl/hci_core_arbiter_tracked_if.sv
// HCI core request/response bundle; master = initiator side, slave = target side.
interface hci_core_arbiter_tracked_if
  import hci_core_arbiter_tracked_pkg::*;
#(
  parameter int unsigned AW = DEFAULT_AW,
  parameter int unsigned DW = DEFAULT_DW
) ();

  logic                   req;
  logic                   gnt;
  logic [AW-1:0]          add;
  logic                   wen;
  logic [DW-1:0]          data;
  logic [DW/8-1:0]        be;
  logic [HCI_BOFFS_W-1:0] boffs;
  logic                   lrdy;
  logic [DW-1:0]          r_data;
  logic                   r_valid;
  logic                   r_opc;

  modport master (
    output req, add, wen, data, be, boffs, lrdy,
    input  gnt, r_data, r_valid, r_opc
  );

  modport slave (
    input  req, add, wen, data, be, boffs, lrdy,
    output gnt, r_data, r_valid, r_opc
  );

endinterface

// File: rtl/hci_core_arbiter_tracked_resp_tracker.sv
// In-order FIFO of source ids for granted-but-unanswered transactions.
module hci_core_arbiter_tracked_resp_tracker
  import hci_core_arbiter_tracked_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic         push_i,
  input  hci_arb_src_t src_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [CW-1:0] count_o,
  output hci_arb_src_t head_o
);

  hci_arb_src_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointers wrap naturally; occupancy is kept in its own counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= src_i;
  end

endmodule

// File: rtl/hci_core_arbiter_tracked.sv
// Round-robin 2-to-1 HCI core merge with in-order response routing.
module hci_core_arbiter_tracked
  import hci_core_arbiter_tracked_pkg::*;
#(
  parameter  int unsigned AW              = DEFAULT_AW,
  parameter  int unsigned DW              = DEFAULT_DW,
  parameter  int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned CW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  hci_core_arbiter_tracked_if.slave   in0,
  hci_core_arbiter_tracked_if.slave   in1,
  hci_core_arbiter_tracked_if.master  out,
  output logic [CW-1:0]               outstanding_o,
  output logic                        err_o
);

  hci_arb_src_t  sel, prio_q, head;
  logic          sel_req, full, empty, handshake, pop;
  logic          route0, route1, err_q;
  logic [AW-1:0] add_sel;
  logic [DW-1:0] data_sel;

  always_comb begin
    if (in0.req & in1.req) sel = prio_q;
    else if (in1.req)      sel = SRC_IN1;
    else                   sel = SRC_IN0;
  end

  assign sel_req  = (sel == SRC_IN1) ? in1.req  : in0.req;
  assign add_sel  = (sel == SRC_IN1) ? in1.add  : in0.add;
  assign data_sel = (sel == SRC_IN1) ? in1.data : in0.data;

  // Full blocks the request outright so r_valid never reaches out.req combinationally.
  assign out.req   = sel_req & ~full;
  assign out.add   = add_sel;
  assign out.data  = data_sel;
  assign out.wen   = (sel == SRC_IN1) ? in1.wen   : in0.wen;
  assign out.be    = (sel == SRC_IN1) ? in1.be    : in0.be;
  assign out.boffs = (sel == SRC_IN1) ? in1.boffs : in0.boffs;
  assign out.lrdy  = (sel == SRC_IN1) ? in1.lrdy  : in0.lrdy;

  assign handshake = out.req & out.gnt;
  assign in0.gnt   = handshake & (sel == SRC_IN0);
  assign in1.gnt   = handshake & (sel == SRC_IN1);

  hci_core_arbiter_tracked_resp_tracker #(
    .DEPTH (MAX_OUTSTANDING)
  ) i_tracker (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push_i  (handshake),
    .src_i   (sel),
    .pop_i   (pop),
    .full_o  (full),
    .empty_o (empty),
    .count_o (outstanding_o),
    .head_o  (head)
  );

  assign pop    = out.r_valid & ~empty;
  assign route0 = pop & (head == SRC_IN0);
  assign route1 = pop & (head == SRC_IN1);

  assign in0.r_valid = route0;
  assign in0.r_data  = route0 ? out.r_data : '0;
  assign in0.r_opc   = route0 ? out.r_opc  : 1'b0;
  assign in1.r_valid = route1;
  assign in1.r_data  = route1 ? out.r_data : '0;
  assign in1.r_opc   = route1 ? out.r_opc  : 1'b0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q <= SRC_IN0;
      err_q  <= 1'b0;
    end else if (clear_i) begin
      prio_q <= SRC_IN0;
      err_q  <= 1'b0;
    end else begin
      if (handshake) prio_q <= ~sel;
      if (out.r_valid & empty) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;

endmodule
